// File: rtl/uart_word_assembler_pkg.sv
// Shared types and helpers for the UART word assembler.
package uart_word_assembler_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  // Ceiling log2 usable in constant expressions; clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts enabled cycles since the last clear and
// flags the terminal count TOUT_CYC-1. TOUT_CYC=0 never flags.
module uart_gap_timer
  import uart_word_assembler_pkg::*;
#(
  parameter int unsigned TOUT_CYC = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc_c
);

  localparam int unsigned CW = (TOUT_CYC > 1) ? clog2(TOUT_CYC) : 1;
  localparam logic [CW-1:0] TC_VAL = (TOUT_CYC > 0) ? CW'(TOUT_CYC - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_tc_c = (TOUT_CYC != 0) && (cnt_q == TC_VAL);

  // Saturate at the terminal value so the flag holds until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != TC_VAL)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_word_assembler.sv
// Packs consecutive UART bytes into NBYTES-wide words with a separate
// output register, overrun detection and an inter-byte timeout.
module uart_word_assembler
  import uart_word_assembler_pkg::*;
#(
  parameter int unsigned DBIT      = 8,
  parameter int unsigned NBYTES    = 2,
  parameter int unsigned MSB_FIRST = 0,
  parameter int unsigned TOUT_CYC  = 1024,
  localparam int unsigned NBITS_D  = DBIT * NBYTES,
  localparam int unsigned CNTW     = clog2(NBYTES + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rx_done,
  input  logic [DBIT-1:0]    i_rx_data,
  input  logic               i_rd,
  output logic [NBITS_D-1:0] o_word,
  output logic               o_valid,
  output logic               o_overrun,
  output logic               o_timeout,
  output logic [CNTW-1:0]    o_byte_cnt
);

  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NBYTES - 1);

  state_e               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [NBITS_D-1:0]   collect_q, collect_d;
  logic [NBITS_D-1:0]   word_q, word_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_q, timeout_d;
  logic [NBITS_D-1:0]   merged_c;
  logic [CNTW-1:0]      lane_c;
  logic                 last_byte_c;
  logic                 tc_c;
  logic                 timer_clear_c;
  logic                 timer_en_c;

  assign last_byte_c   = i_rx_done && (cnt_q == LAST_IDX);
  assign lane_c        = (MSB_FIRST != 0) ? (LAST_IDX - cnt_q) : cnt_q;
  assign timer_en_c    = (state_q == ST_COLLECT);
  assign timer_clear_c = i_rx_done || (state_q == ST_IDLE);

  uart_gap_timer #(
    .TOUT_CYC (TOUT_CYC)
  ) u_gap_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (timer_clear_c),
    .i_en    (timer_en_c),
    .o_tc_c  (tc_c)
  );

  // Collect register with the incoming byte dropped into its lane.
  always_comb begin
    merged_c = collect_q;
    for (int unsigned k = 0; k < NBYTES; k++) begin
      if (lane_c == CNTW'(k)) merged_c[k*DBIT +: DBIT] = i_rx_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    collect_d = collect_q;
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    timeout_d = 1'b0;

    if (valid_q && i_rd) valid_d = 1'b0;

    if (i_rx_done) begin
      if (last_byte_c) begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        collect_d = '0;
        // A completing word may replace the held one only if it is being taken.
        if (!valid_q || i_rd) begin
          word_d  = merged_c;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        state_d   = ST_COLLECT;
        cnt_d     = cnt_q + CNTW'(1);
        collect_d = merged_c;
      end
    end else if (tc_c && (state_q == ST_COLLECT)) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      collect_d = '0;
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      collect_q <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      collect_q <= collect_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_word     = word_q;
  assign o_valid    = valid_q;
  assign o_overrun  = overrun_q;
  assign o_timeout  = timeout_q;
  assign o_byte_cnt = cnt_q;

endmodule
